// File: rtl/regbus_pkg.sv
// Shared response codes, FSM states and small helpers for the register-bus arbiter.
package regbus_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // One-hot requester mask from a 1-bit requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the last-grant pointer only moves when a grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_valid_c,
  output logic       gnt_idx_c
);

  logic last_q;
  logic last_d;

  // On a tie the requester that did not win last time takes the grant.
  always_comb begin
    gnt_valid_c = |req;
    gnt_idx_c   = 1'b0;
    last_d      = last_q;
    if (req == 2'b11) begin
      gnt_idx_c = ~last_q;
    end else begin
      gnt_idx_c = req[1];
    end
    if (accept && gnt_valid_c) begin
      last_d = gnt_idx_c;
    end
  end

  // Pointer resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regbus_arb.sv
// Two-requester arbiter in front of a single register-decode backend with ack timeout.
module regbus_arb
  import regbus_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = 12,
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT    = 16
) (
  input  logic                                       aclk,
  input  logic                                       aresetn,
  input  logic [1:0]                                 req_valid,
  input  logic [1:0]                                 req_we,
  input  logic [1:0][C_ADDR_WIDTH-3:0]               req_addr,
  input  logic [1:0][C_DATA_WIDTH-1:0]               req_wdata,
  input  logic [1:0][C_DATA_WIDTH/8-1:0]             req_be,
  output logic [1:0]                                 req_done,
  output logic [1:0]                                 req_resp,
  output logic [C_DATA_WIDTH-1:0]                    req_rdata,
  output logic                                       reg_req,
  output logic                                       reg_we,
  output logic [C_ADDR_WIDTH-3:0]                    reg_addr,
  output logic [C_DATA_WIDTH-1:0]                    reg_wdata,
  output logic [C_DATA_WIDTH/8-1:0]                  reg_be,
  input  logic                                       reg_ack,
  input  logic [C_DATA_WIDTH-1:0]                    reg_rdata
);

  localparam int unsigned WA_W  = C_ADDR_WIDTH - 2;
  localparam int unsigned BE_W  = C_DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(C_TIMEOUT + 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   grant_q, grant_d;
  logic                   reg_req_q, reg_req_d;
  logic                   reg_we_q, reg_we_d;
  logic [WA_W-1:0]        reg_addr_q, reg_addr_d;
  logic [C_DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic [BE_W-1:0]        reg_be_q, reg_be_d;
  logic [1:0]             req_done_q, req_done_d;
  logic [1:0]             req_resp_q, req_resp_d;
  logic [C_DATA_WIDTH-1:0] req_rdata_q, req_rdata_d;

  logic gnt_valid_c;
  logic gnt_idx_c;

  rr_arb2 u_rr_arb2 (
    .clk         (aclk),
    .rst_n       (aresetn),
    .req         (req_valid),
    .accept      (state_q == S_IDLE),
    .gnt_valid_c (gnt_valid_c),
    .gnt_idx_c   (gnt_idx_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    reg_req_d   = 1'b0;
    reg_we_d    = reg_we_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_be_d    = reg_be_q;
    req_done_d  = 2'b00;
    req_resp_d  = req_resp_q;
    req_rdata_d = req_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (gnt_valid_c) begin
          grant_d     = gnt_idx_c;
          reg_we_d    = req_we[gnt_idx_c];
          reg_addr_d  = req_addr[gnt_idx_c];
          reg_wdata_d = req_wdata[gnt_idx_c];
          reg_be_d    = req_be[gnt_idx_c];
          reg_req_d   = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An ack on the final timeout cycle still completes as OKAY.
        if (reg_ack) begin
          req_rdata_d = reg_we_q ? '0 : reg_rdata;
          req_resp_d  = RESP_OKAY;
          req_done_d  = onehot2(grant_q);
          state_d     = S_DONE;
        end else if (cnt_q == CNT_W'(C_TIMEOUT - 1)) begin
          req_rdata_d = '0;
          req_resp_d  = RESP_SLVERR;
          req_done_d  = onehot2(grant_q);
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      grant_q     <= 1'b0;
      reg_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_be_q    <= '0;
      req_done_q  <= 2'b00;
      req_resp_q  <= 2'b00;
      req_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      reg_req_q   <= reg_req_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_be_q    <= reg_be_d;
      req_done_q  <= req_done_d;
      req_resp_q  <= req_resp_d;
      req_rdata_q <= req_rdata_d;
    end
  end

  assign req_done  = req_done_q;
  assign req_resp  = req_resp_q;
  assign req_rdata = req_rdata_q;
  assign reg_req   = reg_req_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_be    = reg_be_q;

endmodule

// File: tb/tb_regbus_arb.sv
// Bench for regbus_arb: directed vector table, reset/field-change sequences, random traffic vs a reference model.
module tb_regbus_arb;
  import regbus_pkg::*;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned TO  = 16;
  localparam int unsigned WA  = AW - 2;
  localparam int unsigned BEW = DW / 8;

  logic                  aclk = 1'b0;
  logic                  aresetn;
  logic [1:0]            req_valid;
  logic [1:0]            req_we;
  logic [1:0][WA-1:0]    req_addr;
  logic [1:0][DW-1:0]    req_wdata;
  logic [1:0][BEW-1:0]   req_be;
  logic [1:0]            req_done;
  logic [1:0]            req_resp;
  logic [DW-1:0]         req_rdata;
  logic                  reg_req;
  logic                  reg_we;
  logic [WA-1:0]         reg_addr;
  logic [DW-1:0]         reg_wdata;
  logic [BEW-1:0]        reg_be;
  logic                  reg_ack;
  logic [DW-1:0]         reg_rdata;

  regbus_arb #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_TIMEOUT(TO)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .req_done  (req_done),
    .req_resp  (req_resp),
    .req_rdata (req_rdata),
    .reg_req   (reg_req),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_be    (reg_be),
    .reg_ack   (reg_ack),
    .reg_rdata (reg_rdata)
  );

  always #5 aclk = ~aclk;

  int checks;
  int failures;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference-model state for the access currently in flight.
  int             cyc;
  bit             flight;
  int             exp_idx;
  int             req_cycle;
  int             cur_k;
  logic [DW-1:0]  cur_data;
  logic           snap_we;
  logic [WA-1:0]  snap_addr;
  logic [DW-1:0]  snap_wdata;
  logic [BEW-1:0] snap_be;
  int             model_last;
  bit             ack_sched[int];
  int             max_ack;
  int             force_k;
  bit             force_dv;
  logic [DW-1:0]  force_data;
  logic [1:0]     dropped;

  typedef struct {
    int            idx;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
    int            lat;
  } done_t;
  done_t log_q[$];

  // One clock: observe outputs, score against the model, then drive the backend.
  task automatic tick();
    int  pick;
    bit  ok;
    @(posedge aclk);
    #1;
    cyc++;
    dropped = 2'b00;
    if (reg_req) begin
      chk("single_issue", 64'(flight), 64'(0));
      pick = -1;
      for (int s = 1; s <= 2; s++) begin
        if (pick < 0 && req_valid[(model_last + s) % 2]) pick = (model_last + s) % 2;
      end
      chk("issue_has_request", 64'(pick >= 0), 64'(1));
      if (pick < 0) pick = 0;
      model_last = pick;
      exp_idx    = pick;
      flight     = 1'b1;
      req_cycle  = cyc;
      snap_we    = req_we[pick];
      snap_addr  = req_addr[pick];
      snap_wdata = req_wdata[pick];
      snap_be    = req_be[pick];
      if (force_k >= 0) begin
        cur_k = force_k;
      end else begin
        case ($urandom_range(0, 9))
          0:       cur_k = 15;
          1:       cur_k = 16 + int'($urandom_range(0, 2));
          default: cur_k = int'($urandom_range(0, 6));
        endcase
      end
      cur_data = force_dv ? force_data : DW'($urandom);
      ack_sched[cyc + 1 + cur_k] = 1'b1;
      if (cyc + 1 + cur_k > max_ack) max_ack = cyc + 1 + cur_k;
      chk("issue_fields", 64'({reg_we, reg_addr, reg_wdata, reg_be}),
          64'({snap_we, snap_addr, snap_wdata, snap_be}));
    end else if (flight) begin
      chk("fields_stable", 64'({reg_we, reg_addr, reg_wdata, reg_be}),
          64'({snap_we, snap_addr, snap_wdata, snap_be}));
    end
    if (req_done != 2'b00) begin
      if (!flight) begin
        chk("spurious_done", 64'(req_done), 64'(0));
      end else begin
        ok = (cur_k < int'(TO));
        chk("done_bit", 64'(req_done), 64'((exp_idx == 1) ? 2'b10 : 2'b01));
        chk("done_resp", 64'(req_resp), 64'(ok ? RESP_OKAY : RESP_SLVERR));
        chk("done_rdata", 64'(req_rdata), 64'((ok && !snap_we) ? cur_data : '0));
        chk("done_cycle", 64'(cyc), 64'(req_cycle + 2 + (ok ? cur_k : int'(TO) - 1)));
        log_q.push_back('{exp_idx, req_resp, req_rdata, cyc - req_cycle + 1});
        req_valid[exp_idx] = 1'b0;
        dropped[exp_idx]   = 1'b1;
        flight             = 1'b0;
      end
    end
    reg_ack   = ack_sched.exists(cyc);
    reg_rdata = (reg_ack && flight) ? cur_data : DW'($urandom);
  endtask

  task automatic run_quiet(input int budget);
    int n;
    n = 0;
    while ((req_valid != 2'b00 || flight || cyc <= max_ack) && n < budget) begin
      tick();
      n++;
    end
    chk("quiet_within_budget", 64'((req_valid != 2'b00 || flight) ? 1 : 0), 64'(0));
  endtask

  typedef struct {
    logic [1:0]    v;
    logic [1:0]    we;
    logic [WA-1:0] a0;
    logic [WA-1:0] a1;
    logic [DW-1:0] d;
    int            k;
    logic [DW-1:0] ack_data;
    int            g0;
    int            g1;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
    int            lat;
  } vec_t;
  vec_t vt[8];

  initial begin
    int n;
    checks = 0; failures = 0; cyc = 0; flight = 1'b0; exp_idx = 0; req_cycle = 0;
    cur_k = 0; cur_data = '0; model_last = 1; max_ack = 0; force_k = -1;
    force_dv = 1'b0; force_data = '0; dropped = 2'b00;
    snap_we = 1'b0; snap_addr = '0; snap_wdata = '0; snap_be = '0;
    aresetn = 1'b0; req_valid = 2'b00; req_we = 2'b00; req_addr = '0;
    req_wdata = '0; req_be = '0; reg_ack = 1'b0; reg_rdata = '0;

    //       v      we     a0      a1      wdata         k   ack data      g0 g1  resp         rdata         lat
    vt[0] = '{2'b11, 2'b11, 10'h010, 10'h020, 32'h11112222, 0,  32'hAAAA5555, 0, 1,  RESP_OKAY,   32'h0,        3};
    vt[1] = '{2'b11, 2'b11, 10'h011, 10'h021, 32'h33334444, 0,  32'hAAAA5555, 0, 1,  RESP_OKAY,   32'h0,        3};
    vt[2] = '{2'b01, 2'b00, 10'h001, 10'h000, 32'h0,        0,  32'hDEADBEEF, 0, -1, RESP_OKAY,   32'hDEADBEEF, 3};
    vt[3] = '{2'b10, 2'b00, 10'h000, 10'h005, 32'h0,        2,  32'h12345678, 1, -1, RESP_OKAY,   32'h12345678, 5};
    vt[4] = '{2'b01, 2'b00, 10'h3FF, 10'h000, 32'h0,        19, 32'h55AA55AA, 0, -1, RESP_SLVERR, 32'h0,        18};
    vt[5] = '{2'b10, 2'b00, 10'h000, 10'h002, 32'h0,        15, 32'hCAFEF00D, 1, -1, RESP_OKAY,   32'hCAFEF00D, 18};
    vt[6] = '{2'b11, 2'b00, 10'h030, 10'h031, 32'h0,        3,  32'h0BADF00D, 0, 1,  RESP_OKAY,   32'h0BADF00D, 6};
    vt[7] = '{2'b10, 2'b10, 10'h000, 10'h007, 32'h89ABCDEF, 16, 32'h77777777, 1, -1, RESP_SLVERR, 32'h0,        18};

    repeat (3) @(posedge aclk);
    #1;
    chk("reset_ctrl", 64'({reg_req, req_done, req_resp, reg_we, reg_be}), 64'(0));
    chk("reset_data", 64'({req_rdata, reg_addr}), 64'(0));
    chk("reset_wdata", 64'(reg_wdata), 64'(0));
    aresetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      log_q.delete();
      force_k      = vt[i].k;
      force_dv     = 1'b1;
      force_data   = vt[i].ack_data;
      req_we       = vt[i].we;
      req_addr[0]  = vt[i].a0;
      req_addr[1]  = vt[i].a1;
      req_wdata[0] = vt[i].d;
      req_wdata[1] = ~vt[i].d;
      req_be[0]    = 4'hF;
      req_be[1]    = 4'h3;
      req_valid    = vt[i].v;
      run_quiet(100);
      chk($sformatf("vec%0d_ndone", i), 64'(log_q.size()), 64'((vt[i].g1 >= 0) ? 2 : 1));
      if (log_q.size() > 0) begin
        chk($sformatf("vec%0d_grant0", i), 64'(log_q[0].idx), 64'(vt[i].g0));
        chk($sformatf("vec%0d_resp", i), 64'(log_q[0].resp), 64'(vt[i].resp));
        chk($sformatf("vec%0d_rdata", i), 64'(log_q[0].rdata), 64'(vt[i].rdata));
        chk($sformatf("vec%0d_latency", i), 64'(log_q[0].lat), 64'(vt[i].lat));
      end
      if (log_q.size() > 1) chk($sformatf("vec%0d_grant1", i), 64'(log_q[1].idx), 64'(vt[i].g1));
    end

    // Reset while waiting on the backend abandons the access.
    log_q.delete();
    force_k = 10; force_dv = 1'b0;
    req_we = 2'b00; req_addr[0] = 10'h007; req_valid = 2'b01;
    n = 0;
    while (!flight && n < 10) begin tick(); n++; end
    chk("pre_reset_issue", 64'(flight), 64'(1));
    tick(); tick();
    chk("pre_reset_addr", 64'(reg_addr), 64'(10'h007));
    #2 aresetn = 1'b0;
    #1;
    chk("async_reset_ctrl", 64'({reg_req, req_done, req_resp, reg_we, reg_be}), 64'(0));
    chk("async_reset_data", 64'({req_rdata, reg_addr}), 64'(0));
    chk("async_reset_wdata", 64'(reg_wdata), 64'(0));
    flight = 1'b0; ack_sched.delete(); max_ack = 0; model_last = 1;
    req_valid = 2'b00; reg_ack = 1'b0;
    repeat (2) begin
      @(posedge aclk);
      #1;
      cyc++;
      chk("no_done_in_reset", 64'(req_done), 64'(0));
    end
    aresetn = 1'b1;
    force_k = 0;
    req_we = 2'b00; req_addr[0] = 10'h00A; req_addr[1] = 10'h00B; req_valid = 2'b11;
    run_quiet(60);
    chk("post_reset_ndone", 64'(log_q.size()), 64'(2));
    if (log_q.size() > 0) begin
      chk("post_reset_first_grant", 64'(log_q[0].idx), 64'(0));
      chk("post_reset_latency", 64'(log_q[0].lat), 64'(3));
    end

    // Requester 1 moves its address while its access is in flight.
    log_q.delete();
    force_k = 4;
    req_we[1] = 1'b0; req_addr[1] = 10'h005; req_valid = 2'b10;
    n = 0;
    while (!flight && n < 10) begin tick(); n++; end
    req_addr[1] = 10'h009;
    tick();
    chk("inflight_addr_held", 64'(reg_addr), 64'(10'h005));
    run_quiet(50);
    chk("inflight_ndone", 64'(log_q.size()), 64'(1));

    // Random traffic from both requesters against the model.
    force_k = -1; force_dv = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && !dropped[i] && $urandom_range(0, 3) == 0) begin
          req_we[i]    = 1'($urandom);
          req_addr[i]  = WA'($urandom);
          req_wdata[i] = DW'($urandom);
          req_be[i]    = BEW'($urandom);
          req_valid[i] = 1'b1;
        end
      end
      if (flight && $urandom_range(0, 3) == 0) begin
        req_addr[exp_idx]  = WA'($urandom);
        req_wdata[exp_idx] = DW'($urandom);
      end
    end
    run_quiet(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regbus_arb.md
REGBUS_ARB -- requirements
Module: regbus_arb

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 12, meaning byte-address width; word address is C_ADDR_WIDTH-2 bits.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 32, meaning data width (32 or 64 only).
REQ-003 SHALL have parameter C_TIMEOUT, default 16, meaning cycles in WAIT before a forced SLVERR completion (2..255).
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 aclk  in  1  clock; all logic on rising edge.
REQ-006 aresetn  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  2  per-requester access request, held high until done.
REQ-008 req_we  in  2  per-requester 1=write, 0=read.
REQ-009 req_addr  in  2x(C_ADDR_WIDTH-2)  per-requester word address.
REQ-010 req_wdata  in  2xC_DATA_WIDTH  per-requester write data.
REQ-011 req_be  in  2x(C_DATA_WIDTH/8)  per-requester byte enables.
REQ-012 req_done  out  2  one-cycle completion pulse per requester.
REQ-013 req_resp  out  2  response code (OKAY 00, SLVERR 10), valid with any req_done.
REQ-014 req_rdata  out  C_DATA_WIDTH  read data, valid with req_done.
REQ-015 reg_req  out  1  one-cycle access strobe to the register decode backend.
REQ-016 reg_we, reg_addr, reg_wdata, reg_be  out  1/C_ADDR_WIDTH-2/C_DATA_WIDTH/C_DATA_WIDTH/8  access fields, stable from reg_req until completion.
REQ-017 reg_ack  in  1  backend one-cycle acknowledge.
REQ-018 reg_rdata  in  C_DATA_WIDTH  backend read data, valid with reg_ack.

Function
REQ-019 SHALL implement states S_IDLE, S_ISSUE, S_WAIT, S_DONE.
REQ-020 S_IDLE: any req_valid high -> grant one requester, latch its we/addr/wdata/be into reg_* outputs, go S_ISSUE; else stay.
REQ-021 Arbitration SHALL be round-robin: on simultaneous requests, requester not granted last wins; after reset requester 0 wins first tie.
REQ-022 S_ISSUE: reg_req high exactly this cycle; go S_WAIT.
REQ-023 S_WAIT: reg_ack -> capture reg_rdata (reads; 0 for writes), resp OKAY, go S_DONE.
REQ-024 S_WAIT: no reg_ack after C_TIMEOUT cycles -> rdata 0, resp SLVERR, go S_DONE; reg_ack on the timeout cycle SHALL take priority (OKAY).
REQ-025 S_DONE: req_done[grant] high for this single cycle, other done bit low; go S_IDLE.
REQ-026 Requester SHALL drop req_valid at the edge ending its done cycle; arbiter samples req_valid only in S_IDLE, so one request yields exactly one access.
REQ-027 Latency: req_valid seen in S_IDLE cycle 0 -> reg_req cycle 1 -> reg_ack earliest cycle 2 -> req_done cycle 3.
REQ-028 reg_ack outside S_WAIT SHALL be ignored (late ack after timeout has no effect).
REQ-029 Request changes during an in-flight access SHALL not affect the latched reg_* fields.
REQ-030 Timeout counter SHALL clear on entry to S_WAIT; width ceil(log2(C_TIMEOUT+1)), no wrap.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 aresetn low SHALL asynchronously force S_IDLE, last-grant to requester 1, counter 0, and all outputs 0 (reg_req, req_done, req_resp, req_rdata, reg_*).
REQ-033 Reset mid-access SHALL abandon it with no req_done; first access after release follows REQ-027.

Structure
REQ-034 Package regbus_pkg SHALL hold response constants (OKAY, EXOKAY, SLVERR, DECERR) and the state enum.
REQ-035 Grant logic SHALL be sub-module rr_arb2 (2-way round-robin, registered last-grant, update only on grant).

Verification
REQ-036 Single read: req0 addr 1, backend acks cycle 2 with 0xDEADBEEF -> reg_req cycle 1, req_done[0] cycle 3, rdata 0xDEADBEEF, resp 00.
REQ-037 Simultaneous req0/req1 writes, twice back-to-back -> grant order 0,1,0,1; each sees exactly one done.
REQ-038 No ack, C_TIMEOUT=16 -> req_done after 16 WAIT cycles, resp 10, rdata 0; ack injected 3 cycles later ignored.
REQ-039 Ack on the exact timeout cycle -> resp 00, backend data returned.
REQ-040 aresetn low during S_WAIT -> all outputs 0 immediately, no done; next request completes normally.
REQ-041 req1 changes addr 0x5->0x9 while in flight -> reg_addr stays 0x5 until done.
